// File: rtl/kypd_pkg.sv
// Shared definitions for the keypad emulator: state encoding, key-to-matrix
// index tables and the row/column bit ordering used by the scanning decoder.
package kypd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Row 1 / column 1 sit on bit 3; row 4 / column 4 sit on bit 0.
    localparam int ROW_1_BIT = 3;
    localparam int ROW_4_BIT = 0;
    localparam int COL_1_BIT = 3;
    localparam int COL_4_BIT = 0;

    // Two-bit row/column index per key code, packed {key F, ..., key 0}.
    localparam logic [31:0] KEY_ROW_IDX = {
        2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2,
        2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3
    };
    localparam logic [31:0] KEY_COL_IDX = {
        2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1,
        2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0
    };

    // Index 0 selects bit 3, index 3 selects bit 0; the selected bit is driven low.
    function automatic logic [3:0] onehot_low(input logic [1:0] idx);
        return 4'b1111 ^ (4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/kypd_key_map.sv
// Combinational key decoder: hex key code to one-hot-low row and column masks.
module kypd_key_map
    import kypd_pkg::*;
(
    input  logic [3:0] key_code_i,
    output logic [3:0] row_n_o,
    output logic [3:0] col_n_o
);

    logic [4:0] tbl_base_s;

    // Look up the matrix position of the key and expand it to active-low masks.
    always_comb begin
        tbl_base_s = {key_code_i, 1'b0};
        row_n_o    = onehot_low(KEY_ROW_IDX[tbl_base_s +: 2]);
        col_n_o    = onehot_low(KEY_COL_IDX[tbl_base_s +: 2]);
    end

endmodule

// File: rtl/kypd_emulator.sv
// 4x4 passive keypad emulator: holds one key closed for HOLD_CYCLES, releases
// all keys for GAP_CYCLES, and answers column scans on the row lines meanwhile.
module kypd_emulator
    import kypd_pkg::*;
#(
    parameter int HOLD_CYCLES = 2000000,
    parameter int GAP_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    output logic       press_done
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       row_out_q, row_out_d;
    logic             key_ready_q, busy_q, press_done_q, press_done_d;
    logic [3:0]       map_row_n_s, map_col_n_s;

    // Decode the key that will be held in the coming cycle, so row_out tracks state_d.
    kypd_key_map u_key_map (
        .key_code_i (key_d),
        .row_n_o    (map_row_n_s),
        .col_n_o    (map_col_n_s)
    );

    // Next-state, counter and row-line logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        press_done_d = 1'b0;
        row_out_d    = 4'hF;
        case (state_q)
            ST_IDLE: begin
                if (key_valid && key_ready_q) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                    key_d   = key_code;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    press_done_d = 1'b1;
                end else begin
                    cnt_d        = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // The switch closes only when the scan drives the key's own column low.
        if ((state_d == ST_PRESS) && ((sync2_q | map_col_n_s) != 4'hF)) begin
            row_out_d = map_row_n_s;
        end else begin
            row_out_d = 4'hF;
        end
    end

    // State, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            key_q        <= 4'h0;
            sync1_q      <= 4'hF;
            sync2_q      <= 4'hF;
            row_out_q    <= 4'hF;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            press_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            sync1_q      <= col_in;
            sync2_q      <= sync1_q;
            row_out_q    <= row_out_d;
            key_ready_q  <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            press_done_q <= press_done_d;
        end
    end

    assign row_out    = row_out_q;
    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign press_done = press_done_q;

endmodule

// File: tb/tb_kypd_emulator.sv
// Directed bench for kypd_emulator with HOLD_CYCLES=8, GAP_CYCLES=4.
module tb_kypd_emulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       busy;
    logic       press_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] key;
        logic [3:0] col;
        logic [3:0] exp_row;
    } vec_t;

    vec_t vecs [12];

    kypd_emulator #(.HOLD_CYCLES(8), .GAP_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_in     (col_in),
        .row_out    (row_out),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .press_done (press_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {3'b000, act}, {3'b000, exp});
    endtask

    // One full press with col_in held constant; sampling starts on the accept edge.
    task automatic do_press(input logic [3:0] key, input logic [3:0] col, input logic [3:0] exp_row);
        col_in = col;
        repeat (3) step();
        check("idle_row", row_out, 4'hF);
        check1("idle_ready", key_ready, 1'b1);
        key_code  = key;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("press_row", row_out, exp_row);
            check1("press_busy", busy, 1'b1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            check("gap_row", row_out, 4'hF);
            check1("gap_busy", busy, 1'b1);
            check1("gap_done", press_done, 1'b0);
            step();
        end
        check1("done_pulse", press_done, 1'b1);
        check1("done_busy", busy, 1'b0);
        check1("done_ready", key_ready, 1'b1);
        step();
        check1("done_clear", press_done, 1'b0);
    endtask

    initial begin
        logic [3:0] exp34 [8];

        vecs[0]  = '{key: 4'h5, col: 4'b1011, exp_row: 4'b1011};
        vecs[1]  = '{key: 4'h5, col: 4'b1101, exp_row: 4'b1111};
        vecs[2]  = '{key: 4'hD, col: 4'b1110, exp_row: 4'b1110};
        vecs[3]  = '{key: 4'hA, col: 4'b0000, exp_row: 4'b0111};
        vecs[4]  = '{key: 4'h0, col: 4'b0111, exp_row: 4'b1110};
        vecs[5]  = '{key: 4'h1, col: 4'b0111, exp_row: 4'b0111};
        vecs[6]  = '{key: 4'h9, col: 4'b1101, exp_row: 4'b1101};
        vecs[7]  = '{key: 4'hE, col: 4'b1101, exp_row: 4'b1110};
        vecs[8]  = '{key: 4'h7, col: 4'b1111, exp_row: 4'b1111};
        vecs[9]  = '{key: 4'hB, col: 4'b0110, exp_row: 4'b1011};
        vecs[10] = '{key: 4'hF, col: 4'b1011, exp_row: 4'b1110};
        vecs[11] = '{key: 4'h3, col: 4'b1011, exp_row: 4'b1111};

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        col_in    = 4'hF;
        repeat (3) step();
        check("rst_row", row_out, 4'hF);
        check1("rst_ready", key_ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", press_done, 1'b0);
        rst_n = 1'b1;
        step();
        check1("post_rst_ready", key_ready, 1'b1);
        check1("post_rst_busy", busy, 1'b0);

        for (int v = 0; v < 12; v++) begin
            do_press(vecs[v].key, vecs[v].col, vecs[v].exp_row);
        end

        // Key D while the scan moves off and back onto column 4 (3-cycle lag).
        exp34 = '{4'b1110, 4'b1110, 4'b1110, 4'hF, 4'hF, 4'hF, 4'b1110, 4'b1110};
        col_in = 4'b1110;
        repeat (3) step();
        key_code  = 4'hD;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("scan_row", row_out, exp34[i]);
            if (i == 0) col_in = 4'b0111;
            if (i == 3) col_in = 4'b1110;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            check("scan_gap_row", row_out, 4'hF);
            step();
        end
        check1("scan_done", press_done, 1'b1);
        step();

        // key_valid held: second code only taken on the press_done cycle.
        col_in = 4'b1011;
        repeat (3) step();
        key_code  = 4'h1;
        key_valid = 1'b1;
        step();
        key_code = 4'h2;
        check("hold_k1_row", row_out, 4'hF);
        for (int i = 0; i < 12; i++) begin
            check1("hold_busy", busy, 1'b1);
            check1("hold_ready", key_ready, 1'b0);
            step();
        end
        check1("hold_done", press_done, 1'b1);
        check1("hold_done_busy", busy, 1'b0);
        check1("hold_done_ready", key_ready, 1'b1);
        step();
        key_valid = 1'b0;
        check1("hold_k2_busy", busy, 1'b1);
        check1("hold_k2_done", press_done, 1'b0);
        check("hold_k2_row", row_out, 4'b0111);
        repeat (12) step();
        check1("hold_k2_finish", press_done, 1'b1);
        step();

        // Reset during PRESS of key 0 aborts without press_done.
        col_in = 4'b0111;
        repeat (3) step();
        key_code  = 4'h0;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        check("abort_row_pre", row_out, 4'b1110);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("abort_row", row_out, 4'hF);
        check1("abort_ready", key_ready, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", press_done, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check1("abort_ready_rel", key_ready, 1'b1);
        check1("abort_busy_rel", busy, 1'b0);
        for (int i = 0; i < 14; i++) begin
            check1("abort_no_done", press_done, 1'b0);
            check("abort_idle_row", row_out, 4'hF);
            step();
        end

        // Key A with all columns low; a mid-press request for key 3 is ignored.
        col_in = 4'b0000;
        repeat (3) step();
        key_code  = 4'hA;
        key_valid = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            check("ign_row", row_out, 4'b0111);
            if (i == 3) check1("ign_ready", key_ready, 1'b0);
            key_valid = (i == 3);
            key_code  = (i == 3) ? 4'h3 : 4'hA;
            step();
        end
        key_valid = 1'b0;
        repeat (4) step();
        check1("ign_done", press_done, 1'b1);
        step();
        check1("ign_idle_busy", busy, 1'b0);
        check1("ign_idle_ready", key_ready, 1'b1);
        step();
        check1("ign_no_queue", busy, 1'b0);
        check("ign_idle_row", row_out, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
